// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave over a byte-strobed word memory with WAIT_CYCLES wait states.
// Define SLV_ERR_EN to raise slverr on out-of-range transfers; otherwise slverr is tied low.
module apb_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sel,
  input  logic                    enable,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    slverr
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);
  localparam logic [2:0] CNT_INIT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [IW-1:0]         idx_q;
  logic                  wr_q, oor_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && sel && !enable) begin
        idx_q <= addr[IW+1:2];
        wr_q  <= write;
        oor_q <= {1'b0, addr} >= LIMIT;
      end
    end
  end
  // RESP and any unused encoding fall through to IDLE
  always_comb begin
    state_d = IDLE;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (sel && !enable) begin
        state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        cnt_d   = CNT_INIT;
      end
      WAIT: begin
        state_d = !sel ? IDLE : (cnt_q == 3'd0) ? RESP : WAIT;
        cnt_d   = (sel && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ready = (state_q == RESP) && sel && enable;
    rdata = (ready && !wr_q && !oor_q) ? mem_q[idx_q] : '0;
`ifdef SLV_ERR_EN
    slverr = ready && oor_q;
`else
    slverr = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (ready && wr_q && !oor_q) begin
      for (int i = 0; i < NB; i++)
        if (strb[i]) mem_q[idx_q][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: three slaves (WAIT_CYCLES 1, 0, 3) checked against per-slave word-array models.
module tb_apb_slave_mem;
`ifdef SLV_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel, ready, slverr;
  logic        enable, write;
  logic [31:0] addr, wdata;
  logic [3:0]  strb;
  logic [31:0] rdata [3];
  logic [31:0] mdl [3][64];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_mem #(.WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n), .sel(sel[g]), .enable(enable), .write(write),
      .addr(addr), .wdata(wdata), .strb(strb),
      .rdata(rdata[g]), .ready(ready[g]), .slverr(slverr[g])
    );
  end
  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [14];
  function automatic int wc(input int k);
    return k == 0 ? 1 : k == 1 ? 0 : 3;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic clr_model();
    for (int k = 0; k < 3; k++) for (int j = 0; j < 64; j++) mdl[k][j] = '0;
  endtask
  // Called just after a negedge; returns just after the negedge following the ready cycle.
  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] got);
    int n;
    bit inr;
    logic [31:0] er;
    inr = a < 32'd256;
    er = (!wr && inr) ? mdl[k][a[7:2]] : '0;
    sel = '0; sel[k] = 1'b1; enable = 1'b0; write = wr; addr = a; wdata = d; strb = s;
    #1 chk("setup_ready", {31'd0, ready[k]}, 32'd0);
    @(negedge clk);
    enable = 1'b1;
    n = 1;
    #1;
    while (!ready[k] && n <= 12) begin
      chk("wait_rdata", rdata[k], 32'd0);
      chk("wait_slverr", {31'd0, slverr[k]}, 32'd0);
      @(negedge clk);
      n++;
      #1;
    end
    chk("latency", 32'(n), 32'(wc(k) + 1));
    got = rdata[k];
    chk("rdata", rdata[k], er);
    chk("slverr", {31'd0, slverr[k]}, {31'd0, ERR && !inr});
    if (wr && inr && ready[k])
      for (int i = 0; i < 4; i++) if (s[i]) mdl[k][a[7:2]][i*8 +: 8] = d[i*8 +: 8];
    @(negedge clk);
  endtask
  task automatic idle();
    sel = '0; enable = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] got;
    tbl[0]  = '{1'b1, 32'h08,  32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1]  = '{1'b0, 32'h08,  32'h0,        4'h5, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h04,  32'h11223344, 4'hF, 32'h0};
    tbl[3]  = '{1'b1, 32'h04,  32'h0000AA00, 4'h2, 32'h0};
    tbl[4]  = '{1'b0, 32'h04,  32'h0,        4'h0, 32'h1122AA44};
    tbl[5]  = '{1'b1, 32'h04,  32'hFFFFFFFF, 4'h0, 32'h0};
    tbl[6]  = '{1'b0, 32'h04,  32'h0,        4'hF, 32'h1122AA44};
    tbl[7]  = '{1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 32'h0};
    tbl[8]  = '{1'b0, 32'h100, 32'h0,        4'hF, 32'h0};
    tbl[9]  = '{1'b0, 32'h00,  32'h0,        4'h0, 32'h0};
    tbl[10] = '{1'b0, 32'h0B,  32'h0,        4'h0, 32'hDEADBEEF};
    tbl[11] = '{1'b1, 32'hFC,  32'h01020304, 4'hC, 32'h0};
    tbl[12] = '{1'b0, 32'hFC,  32'h0,        4'h0, 32'h01020000};
    tbl[13] = '{1'b0, 32'h1FC, 32'h0,        4'h0, 32'h0};
    clr_model();
    rst_n = 1'b0; idle(); write = 1'b0; addr = '0; wdata = '0; strb = '0;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdata", rdata[k], 32'd0);
      chk("rst_ready", {31'd0, ready[k]}, 32'd0);
      chk("rst_slverr", {31'd0, slverr[k]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      xfer(0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, got);
      chk($sformatf("tbl%0d", i), got, tbl[i].exp);
    end
    idle();
    @(negedge clk);
    // access phase without a setup must be ignored by IDLE
    sel[0] = 1'b1; enable = 1'b1; write = 1'b1; addr = 32'h08; wdata = '0; strb = 4'hF;
    repeat (4) begin
      #1 chk("idle_no_ready", {31'd0, ready[0]}, 32'd0);
      @(negedge clk);
    end
    xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, got);
    chk("idle_ignored", got, 32'hDEADBEEF);
    // back-to-back with zero wait states
    xfer(1, 1'b1, 32'h00, 32'hA5A50F0F, 4'hF, got);
    xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, got);
    chk("b2b_read", got, 32'hA5A50F0F);
    xfer(1, 1'b1, 32'h100, 32'h77777777, 4'hF, got);
    xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, got);
    chk("oor_no_alias", got, 32'hA5A50F0F);
    // abandon a write during WAIT, then hold an access phase without setup
    idle();
    @(negedge clk);
    sel[2] = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h0C; wdata = 32'h55; strb = 4'hF;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    sel[2] = 1'b0;
    @(negedge clk);
    sel[2] = 1'b1;
    repeat (6) begin
      #1 chk("drop_no_ready", {31'd0, ready[2]}, 32'd0);
      @(negedge clk);
    end
    xfer(2, 1'b0, 32'h0C, 32'h0, 4'h0, got);
    chk("drop_unchanged", got, 32'h0);
    // reset during WAIT of a write
    xfer(2, 1'b1, 32'h0C, 32'h12345678, 4'hF, got);
    sel = '0; sel[2] = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h0C; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstw_ready", {31'd0, ready[2]}, 32'd0);
    chk("rstw_rdata", rdata[2], 32'd0);
    chk("rstw_slverr", {31'd0, slverr[2]}, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    clr_model();
    xfer(2, 1'b0, 32'h0C, 32'h0, 4'h0, got);
    chk("rstw_word", got, 32'h0);
    // reset while a read is returning nonzero data
    xfer(0, 1'b1, 32'h10, 32'hCAFE0001, 4'hF, got);
    sel = '0; sel[0] = 1'b1; enable = 1'b0; write = 1'b0; addr = 32'h10;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    #1 chk("rstr_pre", rdata[0], 32'hCAFE0001);
    #2 rst_n = 1'b0;
    #1;
    chk("rstr_rdata", rdata[0], 32'd0);
    chk("rstr_ready", {31'd0, ready[0]}, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    clr_model();
    for (int j = 0; j < 4; j++) begin
      xfer(0, 1'b0, 32'(j * 8), 32'h0, 4'h0, got);
      idle();
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, got);
    chk("rstr_word", got, 32'h0);
    // randomized traffic against the model
    for (int t = 0; t < 300; t++) begin
      xfer(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 'h11F)),
           $urandom, 4'($urandom_range(0, 15)), got);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(negedge clk);
      end
    end
    idle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, meaning data bus width in bits; byte lanes = DATA_WIDTH/8.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 SHALL provide parameter MEM_DEPTH, default 64, meaning number of DATA_WIDTH-bit words.
REQ-004 SHALL provide parameter WAIT_CYCLES, default 1, range 0..7, meaning wait states inserted before ready.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sel  input  1  slave select.
REQ-008 SHALL have port enable  input  1  access-phase indicator.
REQ-009 SHALL have port write  input  1  1 = write, 0 = read.
REQ-010 SHALL have port addr  input  ADDR_WIDTH  byte address, offset from slave base.
REQ-011 SHALL have port wdata  input  DATA_WIDTH  write data, lane-aligned.
REQ-012 SHALL have port strb  input  DATA_WIDTH/8  byte-lane write enables, valid in access phase.
REQ-013 SHALL have port rdata  output  DATA_WIDTH  read data.
REQ-014 SHALL have port ready  output  1  transfer completion.
REQ-015 SHALL have port slverr  output  1  transfer error.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; word index = addr[log2(MEM_DEPTH)+1:2]; addr[1:0] ignored.
REQ-017 IDLE: on sel=1 & enable=0 (setup), SHALL latch word index, write and range flag, and go to RESP if WAIT_CYCLES=0, else WAIT with wait counter = WAIT_CYCLES-1; otherwise stay IDLE (sel=1 & enable=1 in IDLE is ignored).
REQ-018 WAIT: sel=0 SHALL return to IDLE with no memory effect; counter=0 -> RESP; else decrement, stay WAIT.
REQ-019 RESP: ready SHALL be 1 for exactly this cycle when sel=1 & enable=1; next state IDLE unconditionally; sel=0 in RESP -> ready=0, no memory effect.
REQ-020 Latency: ready SHALL assert WAIT_CYCLES+1 cycles after the setup cycle; back-to-back setups immediately after RESP SHALL be accepted with no idle cycle.
REQ-021 Write in RESP (ready=1, in range): byte lane i SHALL update on the clock edge iff strb[i]=1; strb=0 leaves the word unchanged.
REQ-022 Read in RESP (ready=1, in range): rdata SHALL equal the full stored word regardless of strb; rdata SHALL be 0 in every other cycle.
REQ-023 Out of range (addr >= MEM_DEPTH*4): writes SHALL be suppressed and rdata SHALL be 0.
REQ-024 ready, slverr and rdata SHALL be 0 in IDLE and WAIT.
REQ-025 Illegal/unused FSM encodings SHALL recover to IDLE on the next edge.

Reset
REQ-026 On rst_n=0, FSM SHALL enter IDLE, wait counter and latched fields clear, all memory words clear to 0, outputs rdata=0, ready=0, slverr=0, asynchronously.
REQ-027 Reset asserted mid-transfer SHALL abort it with no memory update; first transfer after release completes normally.

Configuration
REQ-028 Macro SLV_ERR_EN defined: slverr SHALL be 1 in the RESP ready cycle of an out-of-range transfer, else 0.
REQ-029 Macro SLV_ERR_EN undefined: slverr SHALL be tied 0; out-of-range transfers complete with ready=1, no write, rdata=0.

Verification
REQ-030 WAIT_CYCLES=1: write addr=0x08, wdata=0xDEADBEEF, strb=0xF, then read 0x08 -> ready high exactly 2 cycles after each setup, rdata=0xDEADBEEF, slverr=0.
REQ-031 Word 0x04=0x11223344; write wdata=0x0000AA00, strb=0x2 -> readback 0x1122AA44; write with strb=0x0 -> still 0x1122AA44.
REQ-032 WAIT_CYCLES=0, back-to-back write 0x00 then read 0x00 with no idle -> ready in each access cycle, no setup lost, read returns written value.
REQ-033 Write addr=0x100 (MEM_DEPTH=64) -> with SLV_ERR_EN slverr=1 with ready, no memory change; without it slverr=0, ready=1, no change.
REQ-034 Drop sel during WAIT (WAIT_CYCLES=3), write 0x0C=0x55 -> FSM IDLE next cycle, ready never asserted, word 0x0C unchanged.
REQ-035 Assert rst_n=0 in WAIT after filling words -> outputs 0 immediately, all words read 0 after release.
